viterbi_tb_sched: RTL and testbench

Schedules the survivor-path side of the rate-1/2 Viterbi decoder. The block accepts received symbol pairs, enables the branch-metric/ACS stage, and generates survivor-memory write addresses over a ring of NBANK banks. It issues traceback requests to the traceback engine one bank behind the write front, and drives the end-of-stream flush sequence.

---
 rtl/viterbi_tb_sched.sv | 200 ++++++++++++++++++++
 tb/tb_viterbi_tb_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_tb_sched.sv
// Survivor-path scheduler for the rate-1/2 Viterbi decoder.
// Accepts symbol pairs, produces survivor write addresses over a ring of
// NBANK banks, and issues traceback requests one bank behind the write
// front. It also sequences the final traceback requests at end of stream.
module viterbi_tb_sched #(
    parameter int BLK   = 256,
    parameter int NBANK = 4,
    localparam int IW   = $clog2(BLK),
    localparam int BW   = $clog2(NBANK)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_flush,
    output logic             bmc_en,
    output logic             wr_en,
    output logic [BW+IW-1:0] wr_addr,
    output logic             tb_req,
    input  logic             tb_ack,
    output logic [BW-1:0]    tb_bank,
    output logic [IW:0]      tb_len,
    output logic             tb_last,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH1,
        S_FLUSH2,
        S_FLUSH_WAIT
    } state_t;

    localparam logic [IW-1:0] IDX_LAST = IW'(BLK - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW:0]   LEN_FULL = (IW+1)'(BLK);
    localparam logic [BW-1:0] BANK_ONE = BW'(1);

    state_t             state_q, state_d;
    logic [BW-1:0]      wr_bank_q, wr_bank_d;
    logic [IW-1:0]      wr_idx_q, wr_idx_d;
    logic               first_done_q, first_done_d;
    logic               issue_q, issue_d;
    logic [BW-1:0]      pend_bank_q, pend_bank_d;
    logic               wr_en_q, wr_en_d;
    logic [BW+IW-1:0]   wr_addr_q, wr_addr_d;
    logic               tb_req_q, tb_req_d;
    logic [BW-1:0]      tb_bank_q, tb_bank_d;
    logic [IW:0]        tb_len_q, tb_len_d;
    logic               tb_last_q, tb_last_d;

    logic               accept;
    logic               bank_done;
    logic               stall_full;
    logic               flushing;

    // Input acceptance: hold off a bank completion while a request is still
    // outstanding, and refuse all data while the flush sequence is running.
    always_comb begin
        stall_full = tb_req_q && (wr_idx_q == IDX_LAST);
        flushing   = (state_q == S_FLUSH1) || (state_q == S_FLUSH2) ||
                     (state_q == S_FLUSH_WAIT);
        in_ready   = !stall_full && !flushing;
        bmc_en     = in_valid && in_ready;
        accept     = bmc_en;
        bank_done  = accept && (wr_idx_q == IDX_LAST);
    end

    // Next-state logic: write addressing, request handshake and flush sequencing.
    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        wr_idx_d     = wr_idx_q;
        first_done_d = first_done_q;
        issue_d      = 1'b0;
        pend_bank_d  = pend_bank_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        tb_req_d     = tb_req_q && !tb_ack;
        tb_bank_d    = tb_bank_q;
        tb_len_d     = tb_len_q;
        tb_last_d    = tb_last_q;

        if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = {wr_bank_q, wr_idx_q};
            if (bank_done) begin
                wr_idx_d     = '0;
                wr_bank_d    = wr_bank_q + BANK_ONE;
                first_done_d = 1'b1;
                issue_d      = first_done_q;
                pend_bank_d  = wr_bank_q - BANK_ONE;
            end else begin
                wr_idx_d = wr_idx_q + IDX_ONE;
            end
        end

        if (issue_q) begin
            tb_req_d  = 1'b1;
            tb_bank_d = pend_bank_q;
            tb_len_d  = LEN_FULL;
            tb_last_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (in_flush) begin
                    state_d = S_FLUSH1;
                end
            end
            S_FLUSH1: begin
                if (!tb_req_q && !issue_q) begin
                    tb_req_d = 1'b1;
                    if (wr_idx_q == '0) begin
                        tb_bank_d = wr_bank_q - BANK_ONE;
                        tb_len_d  = LEN_FULL;
                        tb_last_d = 1'b1;
                        state_d   = S_FLUSH_WAIT;
                    end else if (first_done_q) begin
                        tb_bank_d = wr_bank_q - BANK_ONE;
                        tb_len_d  = LEN_FULL;
                        tb_last_d = 1'b0;
                        state_d   = S_FLUSH2;
                    end else begin
                        tb_bank_d = wr_bank_q;
                        tb_len_d  = {1'b0, wr_idx_q};
                        tb_last_d = 1'b1;
                        state_d   = S_FLUSH_WAIT;
                    end
                end
            end
            S_FLUSH2: begin
                if (tb_req_q && tb_ack) begin
                    tb_req_d  = 1'b1;
                    tb_bank_d = wr_bank_q;
                    tb_len_d  = {1'b0, wr_idx_q};
                    tb_last_d = 1'b1;
                    state_d   = S_FLUSH_WAIT;
                end
            end
            S_FLUSH_WAIT: begin
                if (tb_req_q && tb_ack) begin
                    state_d      = S_IDLE;
                    wr_bank_d    = '0;
                    wr_idx_d     = '0;
                    first_done_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; async reset discards any pending work.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wr_bank_q    <= '0;
            wr_idx_q     <= '0;
            first_done_q <= 1'b0;
            issue_q      <= 1'b0;
            pend_bank_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            tb_req_q     <= 1'b0;
            tb_bank_q    <= '0;
            tb_len_q     <= '0;
            tb_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            wr_idx_q     <= wr_idx_d;
            first_done_q <= first_done_d;
            issue_q      <= issue_d;
            pend_bank_q  <= pend_bank_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            tb_req_q     <= tb_req_d;
            tb_bank_q    <= tb_bank_d;
            tb_len_q     <= tb_len_d;
            tb_last_q    <= tb_last_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign tb_req  = tb_req_q;
    assign tb_bank = tb_bank_q;
    assign tb_len  = tb_len_q;
    assign tb_last = tb_last_q;
    assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_viterbi_tb_sched.sv
// Scoreboard bench for viterbi_tb_sched with BLK=4, NBANK=4.
// Stimulus pushes hand-computed write addresses and traceback requests;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_viterbi_tb_sched;

    localparam int BLK   = 4;
    localparam int NBANK = 4;

    typedef struct packed {
        logic [1:0] bank;
        logic [2:0] len;
        logic       last;
    } req_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       in_flush;
    logic       bmc_en;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       tb_req;
    logic       tb_ack;
    logic [1:0] tb_bank;
    logic [2:0] tb_len;
    logic       tb_last;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_wr[$];
    req_t       exp_req[$];

    viterbi_tb_sched #(.BLK(BLK), .NBANK(NBANK)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_flush (in_flush),
        .bmc_en   (bmc_en),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .tb_req   (tb_req),
        .tb_ack   (tb_ack),
        .tb_bank  (tb_bank),
        .tb_len   (tb_len),
        .tb_last  (tb_last),
        .busy     (busy)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Monitor: compare every write strobe and every acknowledged request.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                if (exp_wr.size() == 0) begin
                    checkOutput("unexpected_write_addr", int'(wr_addr), -1);
                end else begin
                    checkOutput("wr_addr", int'(wr_addr), int'(exp_wr.pop_front()));
                end
            end
            if (tb_req && tb_ack) begin
                if (exp_req.size() == 0) begin
                    checkOutput("unexpected_tb_req", int'({tb_bank, tb_len, tb_last}), -1);
                end else begin
                    checkOutput("tb_req_fields", int'({tb_bank, tb_len, tb_last}),
                                int'(exp_req.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        in_valid = 1'b0;
        in_flush = 1'b0;
        rst      = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic pushWrites(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            exp_wr.push_back(4'((first + i) % 16));
        end
    endtask

    task automatic pushReq(input int bank, input int len, input int last);
        req_t r;
        r.bank = 2'(bank);
        r.len  = 3'(len);
        r.last = last[0];
        exp_req.push_back(r);
    endtask

    // Offer n symbols back to back; the last one optionally carries in_flush.
    task automatic applyStimulus(input int n, input bit flush_last);
        int budget;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_flush = flush_last && (i == n - 1);
            budget = 0;
            while (!in_ready && budget < 50) begin
                tick();
                budget++;
            end
            if (!in_ready) begin
                checkOutput("in_ready_timeout", 0, 1);
            end
            tick();
        end
        in_valid = 1'b0;
        in_flush = 1'b0;
    endtask

    task automatic pulseFlush();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        int budget = 0;
        while ((exp_wr.size() != 0 || exp_req.size() != 0) && budget < 100) begin
            tick();
            budget++;
        end
        checkOutput(name, exp_wr.size() + exp_req.size(), 0);
    endtask

    initial begin
        tb_ack   = 1'b0;
        in_valid = 1'b0;
        in_flush = 1'b0;
        rst      = 1'b0;
        #2;
        checkOutput("reset_in_ready", int'(in_ready), 1);
        checkOutput("reset_outputs", int'({wr_en, wr_addr, tb_req, tb_bank, tb_len, tb_last, busy}), 0);
        doReset();

        $display("[TB] streaming 8 symbols with tb_ack high");
        tb_ack = 1'b1;
        pushWrites(0, 8);
        pushReq(0, 4, 0);
        applyStimulus(8, 1'b0);
        waitDrain("drain_stream8");

        $display("[TB] backpressure with tb_ack low");
        doReset();
        tb_ack = 1'b0;
        pushWrites(0, 12);
        pushReq(0, 4, 0);
        pushReq(1, 4, 0);
        applyStimulus(11, 1'b0);
        in_valid = 1'b1;
        checkOutput("stall_in_ready", int'(in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_hold_in_ready", int'(in_ready), 0);
        end
        tb_ack = 1'b1;
        tick();
        checkOutput("resume_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        waitDrain("drain_backpressure");

        $display("[TB] 6 symbols then flush");
        doReset();
        tb_ack = 1'b1;
        pushWrites(0, 6);
        pushReq(0, 4, 0);
        pushReq(1, 2, 1);
        applyStimulus(6, 1'b0);
        pulseFlush();
        checkOutput("flush_in_ready", int'(in_ready), 0);
        checkOutput("flush_busy", int'(busy), 1);
        waitDrain("drain_flush6");
        tick();
        checkOutput("flush6_idle_busy", int'(busy), 0);

        $display("[TB] flush coinciding with the 8th accept");
        doReset();
        tb_ack = 1'b1;
        pushWrites(0, 8);
        pushReq(0, 4, 0);
        pushReq(1, 4, 1);
        applyStimulus(8, 1'b1);
        waitDrain("drain_flush8");
        tick();
        checkOutput("flush8_idle_busy", int'(busy), 0);

        $display("[TB] 2 symbols then flush, then flush in idle");
        doReset();
        tb_ack = 1'b1;
        pushWrites(0, 2);
        pushReq(0, 2, 1);
        applyStimulus(2, 1'b0);
        pulseFlush();
        waitDrain("drain_flush2");
        tick();
        checkOutput("flush2_idle_busy", int'(busy), 0);
        pulseFlush();
        tick();
        tick();
        checkOutput("idle_flush_no_req", int'(tb_req), 0);
        checkOutput("idle_flush_busy", int'(busy), 0);

        $display("[TB] ring wrap over 20 symbols");
        doReset();
        tb_ack = 1'b1;
        pushWrites(0, 16);
        pushWrites(0, 4);
        for (int b = 0; b < 4; b++) begin
            pushReq(b, 4, 0);
        end
        applyStimulus(20, 1'b0);
        waitDrain("drain_wrap");

        $display("[TB] async reset with a request outstanding");
        tb_ack = 1'b0;
        pushWrites(4, 4);
        applyStimulus(4, 1'b0);
        begin
            int budget = 0;
            while (!tb_req && budget < 20) begin
                tick();
                budget++;
            end
        end
        checkOutput("pending_req_before_reset", int'(tb_req), 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_outputs", int'({wr_en, wr_addr, tb_req, tb_bank, tb_len, tb_last, busy}), 0);
        checkOutput("async_reset_in_ready", int'(in_ready), 1);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("leftover_expectations", exp_wr.size() + exp_req.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
